// File: rtl/exec_unit_md_pkg.sv
// Shared constants and types for the pipelined MIPS execute unit.
package exec_md_pkg;

  localparam logic [5:0] MFHI  = 6'h10;
  localparam logic [5:0] MTHI  = 6'h11;
  localparam logic [5:0] MFLO  = 6'h12;
  localparam logic [5:0] MTLO  = 6'h13;
  localparam logic [5:0] MULT  = 6'h18;
  localparam logic [5:0] MULTU = 6'h19;
  localparam logic [5:0] DIV   = 6'h1A;
  localparam logic [5:0] DIVU  = 6'h1B;

  // Divide by zero: every quotient bit set, HI returns the dividend untouched.
  localparam logic DIVZ_LO_FILL = 1'b1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_e;

  // Low two func bits of the mult/div group select the operation.
  typedef enum logic [1:0] {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU} md_op_e;

  typedef enum logic [2:0] {
    ALU_ADDU, ALU_ADD, ALU_SUBU, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT
  } alu_ctrl_e;

  function automatic alu_ctrl_e decode_func(input logic [5:0] f);
    case (f)
      6'h20:   return ALU_ADD;
      6'h21:   return ALU_ADDU;
      6'h22:   return ALU_SUB;
      6'h23:   return ALU_SUBU;
      6'h24:   return ALU_AND;
      6'h25:   return ALU_OR;
      6'h26:   return ALU_XOR;
      6'h2A:   return ALU_SLT;
      default: return ALU_ADDU;
    endcase
  endfunction

  function automatic logic is_md_func(input logic [5:0] f);
    return f[5:2] == 4'b0110;
  endfunction

endpackage

// File: rtl/exec_unit_md_md_iter.sv
// Radix-2 iterative multiply/divide: shift-add multiply, restoring divide,
// both on operand magnitudes with sign fixup applied to the final result.
module md_iter
  import exec_md_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            step,
  input  md_op_e          op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            last,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = $clog2(XLEN);

  logic [CW-1:0]     cnt_p;
  logic [XLEN-1:0]   acc_p, sh_p, dsr_p, dvd_p;
  logic              neg_q_p, neg_r_p, is_div_p, div0_p;
  logic              sgn, sa, sb;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     sum, shifted, diff;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem;

  assign sgn     = (op == MD_MULT) || (op == MD_DIV);
  assign sa      = sgn & a[XLEN-1];
  assign sb      = sgn & b[XLEN-1];
  assign mag_a   = sa ? -a : a;
  assign mag_b   = sb ? -b : b;
  assign sum     = {1'b0, acc_p} + (sh_p[0] ? {1'b0, dsr_p} : '0);
  assign shifted = {acc_p, sh_p[XLEN-1]};
  assign diff    = shifted - {1'b0, dsr_p};
  assign last    = step && (cnt_p == CW'(XLEN - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        cnt_p <= '0;
    else if (start) cnt_p <= '0;
    else if (step)  cnt_p <= cnt_p + CW'(1);
  end

  // Iteration registers: acc_p is the product high half / partial remainder,
  // sh_p the multiplier being shifted out / quotient being shifted in.
  always_ff @(posedge clk) begin
    if (start) begin
      acc_p    <= '0;
      sh_p     <= mag_a;
      dsr_p    <= mag_b;
      dvd_p    <= a;
      neg_q_p  <= sa ^ sb;
      neg_r_p  <= sa;
      is_div_p <= op[1];
      div0_p   <= (b == '0);
    end else if (step) begin
      if (!is_div_p) begin
        acc_p <= sum[XLEN:1];
        sh_p  <= {sum[0], sh_p[XLEN-1:1]};
      end else if (!diff[XLEN]) begin
        acc_p <= diff[XLEN-1:0];
        sh_p  <= {sh_p[XLEN-2:0], 1'b1};
      end else begin
        acc_p <= shifted[XLEN-1:0];
        sh_p  <= {sh_p[XLEN-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    prod = neg_q_p ? -{acc_p, sh_p} : {acc_p, sh_p};
    quo  = neg_q_p ? -sh_p : sh_p;
    rem  = neg_r_p ? -acc_p : acc_p;
    hi   = prod[2*XLEN-1:XLEN];
    lo   = prod[XLEN-1:0];
    if (is_div_p) begin
      if (div0_p) begin
        lo = {XLEN{DIVZ_LO_FILL}};
        hi = dvd_p;
      end else begin
        lo = quo;
        hi = rem;
      end
    end
  end

endmodule

// File: rtl/exec_unit_md.sv
// Pipelined MIPS EX stage: ALU, immediate extend, branch target, HI/LO and
// iterative mult/div behind a valid/ready output register. Option: FAST_MUL_EN.
module exec_unit_md
  import exec_md_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PCW  = XLEN - 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [PCW-1:0]  pc_plus4,
  input  logic [XLEN-1:0] busA,
  input  logic [XLEN-1:0] busB,
  input  logic [15:0]     imm16,
  input  logic [5:0]      func,
  input  logic            ExtOp,
  input  logic            ALUSrc,
  input  logic [2:0]      ALUop,
  input  logic            Rtype,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PCW-1:0]  btarg,
  output logic [XLEN-1:0] alu_out,
  output logic            zero,
  output logic            overflow,
  output logic            md_busy
);

  md_state_e              state_p, state_nx;
  alu_ctrl_e              ctrl;
  logic                   accept, out_free, iter_op, md_start, md_last, fast_now;
  logic                   res_ovf, res_zf;
  logic [XLEN-1:0]        ext_imm, rhs, res, hi_p, lo_p, md_hi, md_lo;
  logic signed [XLEN-1:0] a_s, b_s, sum_s, dif_s;

  assign ext_imm  = ExtOp ? XLEN'($signed(imm16)) : XLEN'(imm16);
  assign rhs      = ALUSrc ? ext_imm : busB;
  assign ctrl     = Rtype ? decode_func(func) : alu_ctrl_e'(ALUop);
  assign a_s      = $signed(busA);
  assign b_s      = $signed(rhs);
  assign sum_s    = a_s + b_s;
  assign dif_s    = a_s - b_s;

  assign out_free = !out_valid || out_ready;
  assign in_ready = (state_p == IDLE) && out_free;
  assign accept   = in_valid && in_ready;
  assign md_busy  = (state_p != IDLE);
  assign md_start = accept && iter_op;

`ifdef FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  assign fast_now  = Rtype && ((func == MULT) || (func == MULTU));
  assign iter_op   = Rtype && is_md_func(func) && func[1];
  assign fast_prod = (func == MULT) ? ((2*XLEN)'($signed(busA)) * (2*XLEN)'($signed(busB)))
                                    : ({{XLEN{1'b0}}, busA} * {{XLEN{1'b0}}, busB});
`else
  assign fast_now  = 1'b0;
  assign iter_op   = Rtype && is_md_func(func);
`endif

  always_comb begin
    res     = '0;
    res_ovf = 1'b0;
    case (ctrl)
      ALU_ADDU: res = sum_s;
      ALU_ADD: begin
        res     = sum_s;
        res_ovf = (a_s[XLEN-1] == b_s[XLEN-1]) && (sum_s[XLEN-1] != a_s[XLEN-1]);
      end
      ALU_SUBU: res = dif_s;
      ALU_SUB: begin
        res     = dif_s;
        res_ovf = (a_s[XLEN-1] != b_s[XLEN-1]) && (dif_s[XLEN-1] != a_s[XLEN-1]);
      end
      ALU_AND:  res = busA & rhs;
      ALU_OR:   res = busA | rhs;
      ALU_XOR:  res = busA ^ rhs;
      ALU_SLT:  res[0] = (a_s < b_s);
      default:  res = sum_s;
    endcase
    if (Rtype) begin
      case (func)
        MFHI: begin res = hi_p; res_ovf = 1'b0; end
        MFLO: begin res = lo_p; res_ovf = 1'b0; end
        MTHI, MTLO: begin res = busA; res_ovf = 1'b0; end
`ifdef FAST_MUL_EN
        MULT, MULTU: begin res = fast_prod[XLEN-1:0]; res_ovf = 1'b0; end
`endif
        default: ;
      endcase
    end
    res_zf = (res == '0) && !fast_now;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_p <= IDLE;
    else     state_p <= state_nx;
  end

  always_comb begin
    state_nx = state_p;
    case (state_p)
      IDLE:    if (md_start) state_nx = BUSY;
      BUSY:    if (md_last)  state_nx = DONE;
      DONE:    if (out_free) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  md_iter #(.XLEN(XLEN)) u_md_iter (
    .clk   (clk),
    .rst   (rst),
    .start (md_start),
    .step  (state_p == BUSY),
    .op    (md_op_e'(func[1:0])),
    .a     (busA),
    .b     (busB),
    .last  (md_last),
    .hi    (md_hi),
    .lo    (md_lo)
  );

  // HI/LO: written by an iterative result leaving DONE, or by mthi/mtlo.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_p <= '0;
      lo_p <= '0;
    end else if ((state_p == DONE) && out_free) begin
      hi_p <= md_hi;
      lo_p <= md_lo;
    end else if (accept && Rtype) begin
      if (func == MTHI) hi_p <= busA;
      if (func == MTLO) lo_p <= busA;
`ifdef FAST_MUL_EN
      if (fast_now) begin
        hi_p <= fast_prod[2*XLEN-1:XLEN];
        lo_p <= fast_prod[XLEN-1:0];
      end
`endif
    end
  end

  // EX/MEM output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      btarg     <= '0;
      alu_out   <= '0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
    end else if (accept && !iter_op) begin
      out_valid <= 1'b1;
      btarg     <= pc_plus4 + ext_imm[PCW-1:0];
      alu_out   <= res;
      zero      <= res_zf;
      overflow  <= res_ovf;
    end else if ((state_p == DONE) && out_free) begin
      out_valid <= 1'b1;
      alu_out   <= md_lo;
      zero      <= 1'b0;
      overflow  <= 1'b0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_exec_unit_md.sv
// Scoreboard bench for exec_unit_md: directed cases plus random instruction mix.
module tb_exec_unit_md;

  typedef struct {
    logic [29:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    logic [15:0] imm;
    logic [5:0]  func;
    logic        ext;
    logic        src;
    logic [2:0]  aluop;
    logic        rtype;
  } instr_t;

  typedef struct {
    logic [31:0] alu;
    logic        zero;
    logic        ovf;
    logic [29:0] btarg;
    bit          chk_bt;
  } exp_t;

  logic        clk = 0, rst = 1;
  logic        in_valid = 0, in_ready, out_valid, out_ready = 1, zero, overflow, md_busy;
  logic [29:0] pc_plus4 = 0, btarg;
  logic [31:0] busA = 0, busB = 0, alu_out;
  logic [15:0] imm16 = 0;
  logic [5:0]  func = 0;
  logic        ExtOp = 0, ALUSrc = 0, Rtype = 0;
  logic [2:0]  ALUop = 0;

  int checks = 0, passes = 0;
  exp_t sbq[$];
  logic [31:0] hi_m = 0, lo_m = 0;
  logic [31:0] specials [5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
  logic [5:0]  alu_funcs [8] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2A};

  exec_unit_md dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .pc_plus4(pc_plus4), .busA(busA), .busB(busB), .imm16(imm16), .func(func),
    .ExtOp(ExtOp), .ALUSrc(ALUSrc), .ALUop(ALUop), .Rtype(Rtype),
    .out_valid(out_valid), .out_ready(out_ready), .btarg(btarg), .alu_out(alu_out),
    .zero(zero), .overflow(overflow), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s got %h expected %h", nm, act, exp);
  endtask

  // Reference model: architectural meaning of each instruction.
  task automatic model_accept(input instr_t i);
    exp_t e;
    logic [31:0] ext, rhs;
    longint s, sa, sr;
    logic [63:0] p;
    int op;
    ext = i.ext ? {{16{i.imm[15]}}, i.imm} : {16'h0, i.imm};
    rhs = i.src ? ext : i.b;
    e.btarg = i.pc + ext[29:0];
    e.chk_bt = 1;
    e.ovf = 0;
    e.alu = 0;
    if (i.rtype && (i.func inside {[6'h10:6'h13], [6'h18:6'h1B]})) begin
      case (i.func)
        6'h10: e.alu = hi_m;
        6'h12: e.alu = lo_m;
        6'h11: begin hi_m = i.a; e.alu = i.a; end
        6'h13: begin lo_m = i.a; e.alu = i.a; end
        6'h18: begin
          p = longint'($signed(i.a)) * longint'($signed(i.b));
          hi_m = p[63:32]; lo_m = p[31:0];
        end
        6'h19: begin
          p = {32'h0, i.a} * {32'h0, i.b};
          hi_m = p[63:32]; lo_m = p[31:0];
        end
        6'h1A: begin
          if (i.b == 0) begin lo_m = 32'hFFFFFFFF; hi_m = i.a; end
          else if (i.a == 32'h80000000 && i.b == 32'hFFFFFFFF) begin lo_m = 32'h80000000; hi_m = 0; end
          else begin lo_m = $signed(i.a) / $signed(i.b); hi_m = $signed(i.a) % $signed(i.b); end
        end
        default: begin
          if (i.b == 0) begin lo_m = 32'hFFFFFFFF; hi_m = i.a; end
          else begin lo_m = i.a / i.b; hi_m = i.a % i.b; end
        end
      endcase
      if (i.func >= 6'h18) begin
        e.alu = lo_m; e.zero = 0; e.chk_bt = 0;
      end else e.zero = (e.alu == 0);
    end else begin
      if (i.rtype)
        case (i.func)
          6'h20: op = 1; 6'h21: op = 0; 6'h22: op = 3; 6'h23: op = 2;
          6'h24: op = 4; 6'h25: op = 5; 6'h26: op = 6; default: op = 7;
        endcase
      else op = i.aluop;
      sa = longint'($signed(i.a));
      sr = longint'($signed(rhs));
      case (op)
        0: e.alu = i.a + rhs;
        1: begin s = sa + sr; e.alu = s[31:0]; e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
        2: e.alu = i.a - rhs;
        3: begin s = sa - sr; e.alu = s[31:0]; e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
        4: e.alu = i.a & rhs;
        5: e.alu = i.a | rhs;
        6: e.alu = i.a ^ rhs;
        default: e.alu = (sa < sr) ? 32'd1 : 32'd0;
      endcase
      e.zero = (e.alu == 0);
    end
    sbq.push_back(e);
  endtask

  // Monitor: a transfer happens at the next rising edge when both are high.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #3;
      if (!rst && out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("alu_out", alu_out, e.alu);
          chk("zero", zero, e.zero);
          chk("overflow", overflow, e.ovf);
          if (e.chk_bt) chk("btarg", btarg, e.btarg);
        end
      end
    end
  end

  function automatic instr_t mk(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    instr_t i;
    i.pc = 30'h100; i.a = a; i.b = b; i.imm = 16'h0004; i.func = f;
    i.ext = 1; i.src = 0; i.aluop = 0; i.rtype = 1;
    return i;
  endfunction

  function automatic logic [31:0] pick();
    return ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : 32'($urandom());
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    int k;
    k = $urandom_range(0, 9);
    i.pc = 30'($urandom()); i.a = pick(); i.b = pick();
    i.imm = 16'($urandom()); i.ext = 1'($urandom()); i.src = 1'($urandom());
    i.aluop = 3'($urandom()); i.rtype = 1;
    if (k <= 3) i.func = alu_funcs[$urandom_range(0, 7)];
    else if (k <= 5) begin i.rtype = 0; i.func = 6'($urandom()); end
    else if (k == 6) i.func = 6'h10 + 6'($urandom_range(0, 3));
    else begin
      i.func = 6'h18 + 6'($urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) i.b = 0;
    end
    return i;
  endfunction

  task automatic issue(input instr_t i, input bit rdy1, output int waited);
    bit done_;
    done_ = 0;
    waited = 0;
    while (!done_) begin
      @(negedge clk); #1;
      in_valid = 1; pc_plus4 = i.pc; busA = i.a; busB = i.b; imm16 = i.imm;
      func = i.func; ExtOp = i.ext; ALUSrc = i.src; ALUop = i.aluop; Rtype = i.rtype;
      out_ready = rdy1 ? 1'b1 : ($urandom_range(0, 3) != 0);
      #1;
      if (in_ready) begin
        model_accept(i);
        done_ = 1;
      end else if (++waited > 200) begin
        chk("accept_timeout", waited, 0);
        done_ = 1;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk); #1;
      in_valid = 0; out_ready = 1;
    end
  endtask

  initial begin
    instr_t i;
    int w, busy, bad;
    // Reset state
    @(negedge clk); #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_alu_out", alu_out, 0);
    chk("rst_btarg", btarg, 0);
    chk("rst_zero", zero, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_md_busy", md_busy, 0);
    @(negedge clk); #1 rst = 0; #1;
    chk("rst_in_ready", in_ready, 1);
    issue(mk(6'h10, 0, 0), 1, w);
    issue(mk(6'h12, 0, 0), 1, w);

    // Basic add, then overflow with branch target
    issue(mk(6'h20, 5, 7), 1, w);
    i = mk(6'h20, 32'h7FFFFFFF, 1); i.imm = 16'hFFFF;
    issue(i, 1, w);

    // mult latency: busy for XLEN + 1 cycles, in_ready low throughout
    issue(mk(6'h18, 32'hFFFFFFFF, 3), 1, w);
    busy = 0; bad = 0;
    repeat (45) begin
      @(negedge clk); #1 in_valid = 0; out_ready = 1; #1;
      if (md_busy) begin busy++; if (in_ready) bad++; end
    end
`ifdef FAST_MUL_EN
    chk("mult_busy_cycles", busy, 0);
`else
    chk("mult_busy_cycles", busy, 33);
`endif
    chk("mult_in_ready_low", bad, 0);
    issue(mk(6'h10, 0, 0), 1, w);

    // Divide corner cases
    issue(mk(6'h1B, 10, 0), 1, w);
    issue(mk(6'h10, 0, 0), 1, w);
    issue(mk(6'h1A, 32'h80000000, 32'hFFFFFFFF), 1, w);
    issue(mk(6'h10, 0, 0), 1, w);
    idle(2);

    // Backpressure hold, then same-cycle accept on release
    issue(mk(6'h20, 5, 7), 1, w);
    repeat (3) begin
      @(negedge clk); #1 in_valid = 0; out_ready = 0; #1;
      chk("hold_out_valid", out_valid, 1);
      chk("hold_alu_out", alu_out, 12);
      chk("hold_in_ready", in_ready, 0);
    end
    issue(mk(6'h22, 9, 4), 1, w);
    chk("release_accept_wait", w, 0);
    idle(2);

    // Reset in the middle of a divide
    issue(mk(6'h1A, 1000, 7), 1, w);
    idle(10);
    @(negedge clk); #1 rst = 1;
    void'(sbq.pop_back());
    hi_m = 0; lo_m = 0;
    @(negedge clk); #1 rst = 0; #1;
    chk("rstmid_out_valid", out_valid, 0);
    chk("rstmid_md_busy", md_busy, 0);
    chk("rstmid_in_ready", in_ready, 1);
    issue(mk(6'h10, 0, 0), 1, w);
    issue(mk(6'h12, 0, 0), 1, w);

    // Random mix with random downstream backpressure
    for (int n = 0; n < 160; n++) begin
      issue(rand_instr(), 0, w);
      if ($urandom_range(0, 4) == 0) begin
        @(negedge clk); #1 in_valid = 0;
      end
    end
    idle(60);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
